// File: rtl/jk_reg_bank_if.sv
// Bus bundle for jk_reg_bank: update controls and inputs in, bank state and change status out.
interface jk_reg_bank_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             sout;
  logic             changed;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output en, mode, j, k, d, sin,
    input  q, qn, sout, changed, chg_cnt
  );

  modport slave (
    input  en, mode, j, k, d, sin,
    output q, qn, sout, changed, chg_cnt
  );
endinterface

// File: rtl/jk_reg_bank.sv
// Bank of JK flip-flops with parallel load, shift-left and count-up modes,
// plus a change pulse and a saturating change counter.
module jk_reg_bank #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      CNT_W   = 4
) (
  input logic             clk,
  input logic             rst,
  jk_reg_bank_if.slave    bus
);

  typedef enum logic [1:0] {
    ModeJk    = 2'b00,
    ModeLoad  = 2'b01,
    ModeShift = 2'b10,
    ModeCount = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q;
  logic [CNT_W-1:0] cnt_q;

  // Mode is only decoded under en, so don't-care inputs while idle never reach q.
  always_comb begin
    q_d = q_q;
    if (bus.en) begin
      case (mode_e'(bus.mode))
        ModeJk:    q_d = (bus.j & ~q_q) | (~bus.k & q_q);
        ModeLoad:  q_d = bus.d;
        ModeShift: q_d = {q_q[WIDTH-2:0], bus.sin};
        ModeCount: q_d = q_q + WIDTH'(1);
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= RST_VAL;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      q_q       <= q_d;
      changed_q <= (q_d != q_q);
      if ((q_d != q_q) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.q       = q_q;
  assign bus.qn      = ~q_q;
  assign bus.sout    = q_q[WIDTH-1];
  assign bus.changed = changed_q;
  assign bus.chg_cnt = cnt_q;

endmodule
